mem_access_ctrl: RTL and testbench

//  MEM-stage load/store unit sitting directly upstream of the load extender. It checks alignment,

---
 rtl/mem_access_ctrl.sv | 93 +++++++++
 tb/tb_mem_access_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store unit. It checks alignment, drives the SRAM-like data bus,
// stalls the pipeline until the access completes, then hands the raw read word and byte offset to the load extender.
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic [5:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic              flush,
  input  logic              mem_hold,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic [31:0]       readdata,
  output logic [1:0]        offset,
  output logic              mem_stall,
  output logic              adel,
  output logic              ades,
  output logic [ADDR_W-1:0] badvaddr
);
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
                         OP_LHU = 6'h25, OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic is_load, is_store, is_half, is_word, misaligned, start, complete, cancel, cancel_eff, capture;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  assign is_load    = mem_op == OP_LB || mem_op == OP_LBU || mem_op == OP_LH || mem_op == OP_LHU || mem_op == OP_LW;
  assign is_store   = mem_op == OP_SB || mem_op == OP_SH || mem_op == OP_SW;
  assign is_half    = mem_op == OP_LH || mem_op == OP_LHU || mem_op == OP_SH;
  assign is_word    = mem_op == OP_LW || mem_op == OP_SW;
  assign misaligned = (is_half & mem_addr[0]) | (is_word & |mem_addr[1:0]);
  assign adel       = mem_valid & is_load & misaligned;
  assign ades       = mem_valid & is_store & misaligned;
  assign badvaddr   = mem_addr;
  assign start      = mem_valid & (is_load | is_store) & ~misaligned & ~flush;
  assign size       = is_word ? 2'd2 : is_half ? 2'd1 : 2'd0;
  assign wstrb      = !is_store ? 4'b0000 : is_word ? 4'b1111 :
                      is_half ? (mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << mem_addr[1:0];
  assign wdata      = is_word ? mem_wdata : is_half ? {2{mem_wdata[15:0]}} : {4{mem_wdata[7:0]}};
  assign data_req   = state == REQ;
  assign mem_stall  = ((state == IDLE || state == DONE) & start) | state == REQ | state == WAIT;
  assign complete   = (state == REQ & data_addr_ok & data_data_ok) | (state == WAIT & data_data_ok);
  // a flush landing on the completing cycle still discards that access
  assign cancel_eff = cancel | flush;
  assign capture    = (state == IDLE || state == DONE) && state_nx == REQ;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? REQ : IDLE;
      REQ:  state_nx = complete ? (cancel_eff ? IDLE : DONE) : data_addr_ok ? WAIT : REQ;
      WAIT: state_nx = complete ? (cancel_eff ? IDLE : DONE) : WAIT;
      DONE: state_nx = mem_hold ? DONE : start ? REQ : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cancel     <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= '0;
      data_wstrb <= 4'd0;
      data_wdata <= 32'd0;
      readdata   <= 32'd0;
      offset     <= 2'd0;
    end else begin
      state  <= state_nx;
      cancel <= complete ? 1'b0 : ((state == REQ || state == WAIT) && flush) ? 1'b1 : cancel;
      if (capture) begin
        data_wr    <= is_store;
        data_size  <= size;
        data_addr  <= mem_addr;
        data_wstrb <= wstrb;
        data_wdata <= wdata;
      end
      if (complete && !data_wr && !cancel_eff) begin
        readdata <= data_rdata;
        offset   <= data_addr[1:0];
      end
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: vector table, directed multi-cycle sequences and a random run against a transaction-level model.
module tb_mem_access_ctrl;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25,
                         SB = 6'h28, SH = 6'h29, SW = 6'h2b;
  logic clk = 0, resetn = 0, mem_valid = 0, flush = 0, mem_hold = 0, aok = 0, dok = 0;
  logic [5:0] mem_op = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0, rdata = 0;
  logic data_req, data_wr, mem_stall, adel, ades;
  logic [1:0] data_size, offset;
  logic [31:0] data_addr, data_wdata, readdata, badvaddr;
  logic [3:0] data_wstrb;
  int ncmp = 0, nerr = 0;
  always #5 clk = ~clk;
  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .flush(flush), .mem_hold(mem_hold), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(aok), .data_data_ok(dok), .data_rdata(rdata), .readdata(readdata), .offset(offset),
    .mem_stall(mem_stall), .adel(adel), .ades(ades), .badvaddr(badvaddr));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
    mem_valid = 1; mem_op = op; mem_addr = a; mem_wdata = wd;
  endtask
  function automatic int nbytes(input logic [5:0] op);
    if (op == LB || op == LBU || op == SB) return 1;
    if (op == LH || op == LHU || op == SH) return 2;
    if (op == LW || op == SW) return 4;
    return 0;
  endfunction
  function automatic bit is_st(input logic [5:0] op);
    return op == SB || op == SH || op == SW;
  endfunction
  typedef struct {
    logic [5:0] op; logic [31:0] addr, wdata;
    logic e_adel, e_ades, e_issue, e_wr; logic [1:0] e_size; logic [3:0] e_wstrb; logic [31:0] e_wdata;
  } vec_t;
  vec_t vecs[10];
  bit busy, acc, canc, done, m_st, start, c;
  int m_nb;
  logic [31:0] m_addr, m_wd, m_rd;
  logic [1:0] m_off;
  logic [5:0] ops[9];
  initial begin
    vecs[0] = '{SB,  32'h1003, 32'h000000A5, 0, 0, 1, 1, 2'd0, 4'b1000, 32'hA5A5A5A5};
    vecs[1] = '{SH,  32'h1002, 32'h00001234, 0, 0, 1, 1, 2'd1, 4'b1100, 32'h12341234};
    vecs[2] = '{LH,  32'h1001, 32'h0,        1, 0, 0, 0, 2'd1, 4'b0000, 32'h0};
    vecs[3] = '{SW,  32'h1006, 32'h0,        0, 1, 0, 0, 2'd2, 4'b0000, 32'h0};
    vecs[4] = '{SW,  32'h1000, 32'h12345678, 0, 0, 1, 1, 2'd2, 4'b1111, 32'h12345678};
    vecs[5] = '{LB,  32'h1003, 32'h0,        0, 0, 1, 0, 2'd0, 4'b0000, 32'h0};
    vecs[6] = '{SH,  32'h1001, 32'h0000FFFF, 0, 1, 0, 0, 2'd1, 4'b0000, 32'h0};
    vecs[7] = '{SB,  32'h1001, 32'hABCDEF12, 0, 0, 1, 1, 2'd0, 4'b0010, 32'h12121212};
    vecs[8] = '{LW,  32'h1004, 32'h0,        0, 0, 1, 0, 2'd2, 4'b0000, 32'h0};
    vecs[9] = '{6'h0F, 32'h1000, 32'h0,      0, 0, 0, 0, 2'd0, 4'b0000, 32'h0};
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, 6'h0F};
    #1;
    chk("reset_req", data_req, 0); chk("reset_stall", mem_stall, 0);
    chk("reset_readdata", readdata, 0); chk("reset_offset", offset, 0);
    step(); step(); resetn = 1;
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      chk($sformatf("v%0d_adel", i), adel, vecs[i].e_adel);
      chk($sformatf("v%0d_ades", i), ades, vecs[i].e_ades);
      chk($sformatf("v%0d_stall", i), mem_stall, vecs[i].e_issue);
      if (vecs[i].e_adel || vecs[i].e_ades) chk($sformatf("v%0d_badvaddr", i), badvaddr, vecs[i].addr);
      step(); mem_valid = 0;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), data_req, vecs[i].e_issue);
      if (vecs[i].e_issue) begin
        chk($sformatf("v%0d_wr", i), data_wr, vecs[i].e_wr);
        chk($sformatf("v%0d_size", i), data_size, vecs[i].e_size);
        chk($sformatf("v%0d_wstrb", i), data_wstrb, vecs[i].e_wstrb);
        chk($sformatf("v%0d_addr", i), data_addr, vecs[i].addr);
        if (vecs[i].e_wr) chk($sformatf("v%0d_wdata", i), data_wdata, vecs[i].e_wdata);
        aok = 1; dok = 1; step(); aok = 0; dok = 0; step();
      end
    end
    // LW with delayed handshakes: four stall cycles then DONE
    issue(LW, 32'h1000, 0);
    @(negedge clk); chk("lw_stall0", mem_stall, 1);
    step(); mem_valid = 0;
    @(negedge clk); chk("lw_req1", data_req, 1); chk("lw_stall1", mem_stall, 1);
    step(); aok = 1;
    @(negedge clk); chk("lw_stall2", mem_stall, 1);
    step(); aok = 0; dok = 1; rdata = 32'hDEADBEEF;
    @(negedge clk); chk("lw_req3", data_req, 0); chk("lw_stall3", mem_stall, 1);
    step(); dok = 0;
    @(negedge clk); chk("lw_done_stall", mem_stall, 0);
    chk("lw_readdata", readdata, 32'hDEADBEEF); chk("lw_offset", offset, 0);
    step();
    // flushed load: bus completes, data dropped, FSM lands in IDLE
    issue(LW, 32'h1010, 0);
    @(negedge clk); step(); mem_valid = 0; flush = 1;
    @(negedge clk); chk("fl_req0", data_req, 1);
    step(); flush = 0; aok = 1;
    @(negedge clk); chk("fl_req_held", data_req, 1);
    step(); aok = 0; flush = 1;
    @(negedge clk); chk("fl_wait_req", data_req, 0); chk("fl_wait_stall", mem_stall, 1);
    step(); flush = 0; dok = 1; rdata = 32'h11111111;
    @(negedge clk); step(); dok = 0; mem_hold = 1; issue(LW, 32'h1020, 0);
    @(negedge clk); chk("fl_keep_readdata", readdata, 32'hDEADBEEF); chk("fl_idle_stall", mem_stall, 1);
    step(); mem_valid = 0; mem_hold = 0;
    @(negedge clk); chk("fl_went_idle", data_req, 1);
    aok = 1; dok = 1; rdata = 32'h22222222;
    step(); aok = 0; dok = 0;
    @(negedge clk); chk("fl_next_readdata", readdata, 32'h22222222);
    step();
    // back-to-back LBU then LW: DONE goes straight to REQ
    issue(LBU, 32'h2002, 0);
    @(negedge clk); step(); mem_valid = 0; aok = 1; dok = 1; rdata = 32'hAABBCCDD;
    @(negedge clk); chk("b2b_req0", data_req, 1); chk("b2b_size0", data_size, 0); chk("b2b_wstrb0", data_wstrb, 0);
    step(); aok = 0; dok = 0; issue(LW, 32'h2004, 0);
    @(negedge clk); chk("b2b_off0", offset, 2); chk("b2b_rd0", readdata, 32'hAABBCCDD); chk("b2b_stall", mem_stall, 1);
    step(); mem_valid = 0;
    @(negedge clk); chk("b2b_req1", data_req, 1); chk("b2b_addr1", data_addr, 32'h2004); chk("b2b_size1", data_size, 2);
    aok = 1; dok = 1; rdata = 32'h55667788;
    step(); aok = 0; dok = 0;
    @(negedge clk); chk("b2b_off1", offset, 0); chk("b2b_rd1", readdata, 32'h55667788);
    step();
    // asynchronous reset in REQ
    issue(LW, 32'h3000, 0);
    step(); mem_valid = 0;
    @(negedge clk); chk("rst_req_before", data_req, 1);
    #2 resetn = 0;
    #1 chk("rst_req_after", data_req, 0); chk("rst_readdata", readdata, 0); chk("rst_stall", mem_stall, 0);
    step(); resetn = 1;
    busy = 0; acc = 0; canc = 0; done = 0; m_rd = 0; m_off = 0; m_st = 0; m_nb = 1; m_addr = 0; m_wd = 0;
    for (int n = 0; n < 3000; n++) begin
      int nb;
      bit ld, st, fault;
      mem_valid = $urandom_range(0, 9) < 7;
      mem_op = ops[$urandom_range(0, 8)];
      mem_addr = 32'h1000 | $urandom_range(0, 15);
      mem_wdata = $urandom();
      flush = $urandom_range(0, 9) == 0;
      mem_hold = $urandom_range(0, 4) == 0;
      aok = $urandom_range(0, 9) < 4;
      dok = $urandom_range(0, 9) < 4;
      rdata = $urandom();
      nb = nbytes(mem_op);
      st = is_st(mem_op);
      ld = nb != 0 && !st;
      fault = nb != 0 && (mem_addr % nb) != 0;
      start = mem_valid && (ld || st) && !fault && !flush;
      @(negedge clk);
      chk("r_adel", adel, mem_valid && ld && fault);
      chk("r_ades", ades, mem_valid && st && fault);
      if (adel || ades) chk("r_badvaddr", badvaddr, mem_addr);
      chk("r_stall", mem_stall, busy || start);
      chk("r_req", data_req, busy && !acc);
      chk("r_readdata", readdata, m_rd);
      chk("r_offset", offset, m_off);
      if (busy && !acc) begin
        chk("r_addr", data_addr, m_addr);
        chk("r_wr", data_wr, m_st);
        chk("r_size", data_size, $clog2(m_nb));
        chk("r_wstrb", data_wstrb, m_st ? ((1 << m_nb) - 1) << (m_addr % 4) : 0);
        if (m_st) chk("r_wdata", data_wdata, m_nb == 4 ? m_wd : m_nb == 2 ? m_wd[15:0] * 32'h00010001 : m_wd[7:0] * 32'h01010101);
      end
      @(posedge clk);
      if (busy) begin
        c = acc ? dok : (aok && dok);
        if (c) begin
          done = !(canc || flush);
          if (done && !m_st) begin m_rd = rdata; m_off = m_addr[1:0]; end
          busy = 0; acc = 0; canc = 0;
        end else begin
          if (aok) acc = 1;
          if (flush) canc = 1;
        end
      end else if (!(done && mem_hold)) begin
        done = 0;
        if (start) begin busy = 1; m_st = st; m_nb = nb; m_addr = mem_addr; m_wd = mem_wdata; end
      end
      #1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
